// File: rtl/taxi_meter_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// taxi_meter_ctrl
//
// Trip controller for a taxi meter. It tracks the trip state, turns wheel
// distance strobes and waiting-minute strobes into fare-increment requests,
// lets the flag fare absorb the first BASE_UNITS distance requests of each
// trip, and serialises the two request sources onto a single fare_inc strobe
// for the external fare accumulator.
//
// Parameters
//   STALL_CYC   clk cycles without wheel_tick before RUN drops into WAIT
//   WAIT_MIN    min_tick strobes in WAIT per waiting-fare request
//   DIST_UNIT   wheel_tick strobes per distance-fare request
//   BASE_UNITS  distance requests per trip covered by the flag fare
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start_btn   debounced synchronous level; rising edge starts a trip
//   stop_btn    debounced synchronous level; rising edge ends a trip
//   wheel_tick  one-cycle strobe per wheel distance increment
//   min_tick    one-cycle strobe per elapsed minute
//   state       00 IDLE, 01 RUN, 10 WAIT, 11 HOLD
//   trip_clr    one-cycle strobe clearing the external fare accumulator
//   fare_inc    one-cycle strobe requesting one fare increment
//   fare_src    source of the increment, valid with fare_inc
//               (0 = distance, 1 = waiting)
// -----------------------------------------------------------------------------
module taxi_meter_ctrl #(
    parameter logic [15:0] STALL_CYC  = 16'd50000,
    parameter logic [3:0]  WAIT_MIN   = 4'd10,
    parameter logic [7:0]  DIST_UNIT  = 8'd100,
    parameter logic [3:0]  BASE_UNITS = 4'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       wheel_tick,
    input  logic       min_tick,
    output logic [1:0] state,
    output logic       trip_clr,
    output logic       fare_inc,
    output logic       fare_src
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10,
        ST_HOLD = 2'b11
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e      state_q,      state_d;
    logic        start_prev_q;
    logic        stop_prev_q;
    logic [15:0] stall_q,      stall_d;
    logic [3:0]  wait_cnt_q,   wait_cnt_d;
    logic [7:0]  dist_cnt_q,   dist_cnt_d;
    logic [3:0]  base_cnt_q,   base_cnt_d;
    logic        dist_pend_q,  dist_pend_d;
    logic        wait_pend_q,  wait_pend_d;
    logic        fare_inc_q,   fare_inc_d;
    logic        fare_src_q,   fare_src_d;

    // -------------------------------------------------------------------------
    // Decoded qualifiers
    // -------------------------------------------------------------------------
    logic start_edge;
    logic stop_edge;
    logic trip_active;   // RUN or WAIT: ticks are meaningful
    logic run_tick;      // wheel_tick that the trip accepts
    logic wait_tick;     // min_tick that the trip accepts
    logic dist_wrap;     // this wheel_tick completes a distance unit
    logic wait_wrap;     // this min_tick completes a waiting unit
    logic stall_hit;     // this RUN cycle is the STALL_CYC-th without a tick
    logic enter_run;
    logic dist_req;      // distance unit completed this cycle
    logic dist_charge;   // ... and it is not absorbed by the flag fare
    logic wait_req;      // waiting unit completed this cycle
    logic last_dist;     // fare_inc for distance is on the output now
    logic last_wait;     // fare_inc for waiting is on the output now
    logic grant_dist;
    logic grant_wait;

    // Edges are qualified against the registered previous level. The previous
    // registers come out of reset at 1, so a button held down across reset is
    // not mistaken for a fresh press.
    always_comb begin
        start_edge  = start_btn & ~start_prev_q;
        stop_edge   = stop_btn  & ~stop_prev_q;
        trip_active = (state_q == ST_RUN) || (state_q == ST_WAIT);
        run_tick    = trip_active && wheel_tick;
        wait_tick   = (state_q == ST_WAIT) && min_tick;
        // One extra bit keeps the +1 from wrapping when a unit is at the
        // top of its counter's range.
        dist_wrap   = ({1'b0, dist_cnt_q} + 9'd1)  == {1'b0, DIST_UNIT};
        wait_wrap   = ({1'b0, wait_cnt_q} + 5'd1)  == {1'b0, WAIT_MIN};
        stall_hit   = ({1'b0, stall_q}    + 17'd1) >= {1'b0, STALL_CYC};
    end

    // -------------------------------------------------------------------------
    // Trip FSM: next state and the trip_clr strobe
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default at the top;
    // any path that skipped an assignment would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        trip_clr = 1'b0;
        case (state_q)
            // Only a start press matters here, so a simultaneous stop press
            // loses automatically.
            ST_IDLE, ST_HOLD: begin
                if (start_edge) begin
                    state_d  = ST_RUN;
                    trip_clr = 1'b1;
                end
            end
            // Stop is checked first so it wins over a simultaneous start,
            // a wheel tick or a stall.
            ST_RUN: begin
                if (stop_edge) begin
                    state_d = ST_HOLD;
                end else if (!wheel_tick && stall_hit) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stop_edge) begin
                    state_d = ST_HOLD;
                end else if (wheel_tick) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        enter_run = (state_d == ST_RUN) && (state_q != ST_RUN);
    end

    // -------------------------------------------------------------------------
    // Stall counter: consecutive tick-less RUN cycles, saturating
    // -------------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (enter_run || run_tick) begin
            stall_d = '0;
        end else if (state_q == ST_RUN) begin
            stall_d = stall_hit ? STALL_CYC : stall_q + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Distance, base and waiting counters
    // -------------------------------------------------------------------------
    always_comb begin
        dist_cnt_d = dist_cnt_q;
        dist_req   = 1'b0;
        if (trip_clr) begin
            dist_cnt_d = '0;
        end else if (run_tick) begin
            if (dist_wrap) begin
                dist_cnt_d = '0;
                dist_req   = 1'b1;
            end else begin
                dist_cnt_d = dist_cnt_q + 8'd1;
            end
        end
    end

    // The flag fare covers the first BASE_UNITS distance units of a trip;
    // those requests are swallowed here and never reach the arbiter.
    always_comb begin
        base_cnt_d  = base_cnt_q;
        dist_charge = 1'b0;
        if (trip_clr) begin
            base_cnt_d = '0;
        end else if (dist_req) begin
            if (base_cnt_q < BASE_UNITS) begin
                base_cnt_d = base_cnt_q + 4'd1;
            end else begin
                dist_charge = 1'b1;
            end
        end
    end

    // Counts only while stalled; it is not cleared on WAIT->RUN, so partial
    // minutes accumulate across several stalls of the same trip.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        wait_req   = 1'b0;
        if (trip_clr) begin
            wait_cnt_d = '0;
        end else if (wait_tick) begin
            if (wait_wrap) begin
                wait_cnt_d = '0;
                wait_req   = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pending flags and fare_inc arbiter
    // -------------------------------------------------------------------------
    // Distance has priority, but a source that drove fare_inc in the previous
    // cycle is skipped this cycle so the accumulator never sees two back-to-
    // back increments from one source. A grant is withheld while trip_clr is
    // high: the flags are being discarded with the old trip.
    always_comb begin
        last_dist  = fare_inc_q && !fare_src_q;
        last_wait  = fare_inc_q &&  fare_src_q;
        grant_dist = !trip_clr && dist_pend_q && !last_dist;
        grant_wait = !trip_clr && wait_pend_q && !last_wait && !grant_dist;

        fare_inc_d = grant_dist || grant_wait;
        fare_src_d = grant_wait;

        // A new request in the same cycle as a grant re-arms the flag, so
        // nothing is lost when a source is served and re-requests at once.
        if (trip_clr) begin
            dist_pend_d = 1'b0;
            wait_pend_d = 1'b0;
        end else begin
            dist_pend_d = (dist_pend_q && !grant_dist) || dist_charge;
            wait_pend_d = (wait_pend_q && !grant_wait) || wait_req;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            stall_q      <= '0;
            wait_cnt_q   <= '0;
            dist_cnt_q   <= '0;
            base_cnt_q   <= '0;
            dist_pend_q  <= 1'b0;
            wait_pend_q  <= 1'b0;
            fare_inc_q   <= 1'b0;
            fare_src_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_btn;
            stop_prev_q  <= stop_btn;
            stall_q      <= stall_d;
            wait_cnt_q   <= wait_cnt_d;
            dist_cnt_q   <= dist_cnt_d;
            base_cnt_q   <= base_cnt_d;
            dist_pend_q  <= dist_pend_d;
            wait_pend_q  <= wait_pend_d;
            fare_inc_q   <= fare_inc_d;
            fare_src_q   <= fare_src_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // trip_clr is the only combinational output; it stays low in reset
    // because both edge detectors are held at "previous = 1".
    assign state    = state_q;
    assign fare_inc = fare_inc_q;
    assign fare_src = fare_src_q;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    // Back-to-back strobes from one source would double-charge a single event.
    a_no_repeat_src : assert property (
        @(posedge clk) disable iff (!rst_n)
        (fare_inc_q && fare_inc_d) |-> (fare_src_q != fare_src_d)
    );

    // A trip can only be (re)started from IDLE or HOLD.
    a_clr_state : assert property (
        @(posedge clk) disable iff (!rst_n)
        trip_clr |-> ((state_q == ST_IDLE) || (state_q == ST_HOLD))
    );

endmodule

// File: doc/taxi_meter_ctrl.md
TAXI_METER_CTRL -- requirements
Module: taxi_meter_ctrl

Interface
REQ-001 Parameter STALL_CYC, default 16'd50000: number of consecutive clk cycles without wheel_tick before RUN enters WAIT.
REQ-002 Parameter WAIT_MIN, default 4'd10: number of min_tick strobes in WAIT per waiting-fare request.
REQ-003 Parameter DIST_UNIT, default 8'd100: number of wheel_tick strobes per distance-fare request.
REQ-004 Parameter BASE_UNITS, default 4'd3: number of distance requests per trip absorbed by the flag fare and never charged.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start_btn  input  1  debounced, clk-synchronous level; a rising edge starts a trip.
REQ-008 stop_btn  input  1  debounced, clk-synchronous level; a rising edge ends a trip.
REQ-009 wheel_tick  input  1  one-cycle strobe per wheel distance increment.
REQ-010 min_tick  input  1  one-cycle strobe per elapsed minute.
REQ-011 state  output  2  00 IDLE, 01 RUN, 10 WAIT, 11 HOLD.
REQ-012 trip_clr  output  1  one-cycle strobe that clears the external fare accumulator.
REQ-013 fare_inc  output  1  one-cycle strobe requesting one fare increment.
REQ-014 fare_src  output  1  valid with fare_inc: 0 = distance, 1 = waiting.

Function
REQ-015 FSM transitions:
- IDLE->RUN on start edge; assert trip_clr in that same cycle.
- RUN->WAIT when the stall counter reaches STALL_CYC.
- WAIT->RUN on wheel_tick.
- RUN or WAIT->HOLD on stop edge.
- HOLD->RUN on start edge, with trip_clr asserted.
REQ-016 Edge detection: register start_btn and stop_btn; an edge is current=1 and previous=0. Previous registers reset to 1, so a button held through reset produces no edge.
REQ-017 Simultaneous start and stop edges: stop takes precedence in RUN/WAIT; start takes precedence in IDLE/HOLD.
REQ-018 Stall counter:
- clears on every wheel_tick and on entry to RUN;
- increments in RUN only;
- saturates at STALL_CYC.
REQ-019 Wait counter:
- counts min_tick in WAIT only;
- when it reaches WAIT_MIN, it reloads to 0 and raises the wait request;
- retains its value across WAIT->RUN->WAIT;
- clears on trip_clr.
REQ-020 Distance counter:
- counts wheel_tick in RUN and WAIT;
- when it reaches DIST_UNIT, it reloads to 0 and raises the distance request;
- clears on trip_clr.
REQ-021 Base counter: counts distance requests up to BASE_UNITS. A distance request arriving while the count is below BASE_UNITS is consumed silently with no fare_inc. The counter clears on trip_clr.
REQ-022 Arbitration: one pending flag per source. fare_inc is asserted one cycle after a flag is set. When both flags are set in the same cycle, distance is served first and wait in the next cycle. A pending flag is never lost.
REQ-023 Pending flags and all counters hold their values in HOLD and IDLE. fare_inc still drains flags already pending on entry to HOLD.
REQ-024 Ticks in IDLE or HOLD are ignored. trip_clr clears both pending flags in the same cycle.
REQ-025 fare_inc never asserts for two consecutive cycles with the same fare_src.

Reset
REQ-026 While rst_n=0, all outputs are forced low: state=IDLE, trip_clr=0, fare_inc=0, fare_src=0.
REQ-027 While rst_n=0, all counters and pending flags are 0.
REQ-028 Reset asserted mid-trip aborts immediately. After release, a fresh start edge is required before a new trip begins.

Verification
REQ-029 Reset, then start edge -> trip_clr for 1 cycle and state=01 in the next cycle.
REQ-030 RUN, 400 wheel_ticks (DIST_UNIT=100, BASE_UNITS=3) -> exactly one fare_inc with fare_src=0, after the 400th tick.
REQ-031 RUN with no wheel_tick for STALL_CYC cycles -> state=10; then 20 min_ticks -> two fare_inc strobes with fare_src=1; then one wheel_tick -> state=01.
REQ-032 Distance and wait requests raised in the same cycle -> fare_inc/fare_src=0, then fare_inc/fare_src=1 on the next cycle; no request dropped.
REQ-033 In WAIT, stop edge and start edge in the same cycle -> state=11, fare_inc=0 unless requests are pending; a later start edge -> trip_clr and state=01.
REQ-034 rst_n pulsed low during WAIT with counters nonzero -> outputs low asynchronously; after release, min_tick and wheel_tick produce no fare_inc until a start edge.
